// File: rtl/ahb_pkg.sv
// Shared types and constants for the AHB master controller: FSM state encoding,
// HRESP values and the default-width command record.
package ahb_pkg;

  localparam int AHB_ADDR_WIDTH = 32;
  localparam int AHB_DATA_WIDTH = 32;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } ahb_mst_state_e;

  typedef struct packed {
    logic [AHB_ADDR_WIDTH-1:0] addr;
    logic                      write;
    logic [AHB_DATA_WIDTH-1:0] wdata;
  } ahb_cmd_t;

endpackage

// File: rtl/ahb_master_ctrl_if.sv
// CPU command/response channel plus AHB master-side bus signals, bundled so the
// controller and its environment share one connection point.
interface ahb_master_ctrl_if
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = AHB_ADDR_WIDTH,
  parameter int DATA_WIDTH = AHB_DATA_WIDTH
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_write;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  hbusreq;
  logic                  hgrant;
  logic [ADDR_WIDTH-1:0] haddr;
  logic                  haddr_ctrl;
  logic                  hwrite;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] hdata_s2m;
  logic                  hready_s2m;
  logic                  hresp_s2m;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output hbusreq, haddr, haddr_ctrl, hwrite, hwdata,
    input  hgrant, hdata_s2m, hready_s2m, hresp_s2m
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  hbusreq, haddr, haddr_ctrl, hwrite, hwdata,
    output hgrant, hdata_s2m, hready_s2m, hresp_s2m
  );

endinterface

// File: rtl/ahb_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full and empty
// are distinguished without a separate occupancy counter.
module ahb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ahb_master_ctrl.sv
// AHB bus master: queues CPU commands, arbitrates for the bus, runs each transfer
// through address and data phases, reissues ERROR transfers up to MAX_RETRY times.
module ahb_master_ctrl
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = AHB_ADDR_WIDTH,
  parameter int DATA_WIDTH = AHB_DATA_WIDTH,
  parameter int CMD_DEPTH  = 4,
  parameter int MAX_RETRY  = 2
) (
  input  logic              clk,
  input  logic              rst,
  ahb_master_ctrl_if.master bus
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  ahb_mst_state_e        state;
  cmd_t                  push_cmd;
  cmd_t                  head;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  done;
  logic                  err;
  logic                  can_retry;
  logic [RW-1:0]         retry_cnt;
  logic                  rsp_vld;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_error;

  assign push_cmd = '{addr: bus.cmd_addr, write: bus.cmd_write, wdata: bus.cmd_wdata};
  assign push     = bus.cmd_valid && !full;

  ahb_cmd_fifo #(
    .WIDTH($bits(cmd_t)),
    .DEPTH(CMD_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(push_cmd),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  assign done      = (state == ST_DATA) && bus.hready_s2m;
  assign err       = (bus.hresp_s2m == HRESP_ERROR);
  assign can_retry = (retry_cnt != RETRY_MAX);
  // Head stays queued on a retryable ERROR so it is reissued from IDLE.
  assign pop       = done && (!err || !can_retry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (!empty && bus.hgrant) state <= ST_ADDR;
        ST_ADDR: if (bus.hready_s2m)       state <= ST_DATA;
        ST_DATA: if (bus.hready_s2m)       state <= ST_IDLE;
        default:                           state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (done) begin
      retry_cnt <= (err && can_retry) ? retry_cnt + RW'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld   <= 1'b0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_vld   <= pop;
      rsp_error <= pop && err;
      rsp_data  <= (pop && !err && !head.write) ? bus.hdata_s2m : '0;
    end
  end

  assign bus.cmd_ready  = !full;
  assign bus.rsp_valid  = rsp_vld;
  assign bus.rsp_rdata  = rsp_data;
  assign bus.rsp_err    = rsp_error;
  assign bus.hbusreq    = !empty || (state != ST_IDLE);
  assign bus.haddr_ctrl = (state == ST_ADDR);
  assign bus.haddr      = (state == ST_ADDR) ? head.addr : '0;
  assign bus.hwrite     = (state == ST_ADDR) && head.write;
  assign bus.hwdata     = (state == ST_DATA && head.write) ? head.wdata : '0;

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// Directed bench for ahb_master_ctrl with a response scoreboard and a simple
// slave model that can echo a value derived from the last address phase.
module tb_ahb_master_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        echo;
  logic [31:0] hdata_fix;
  logic [31:0] last_addr;
  int          nchk;
  int          nerr;
  int          rsp_cnt;
  int          aph_cnt;
  exp_t        sb[$];

  ahb_master_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ahb_master_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .CMD_DEPTH (4),
    .MAX_RETRY (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.hdata_s2m = echo ? (last_addr ^ 32'hA5A5_0000) : hdata_fix;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic wait_rsp(input int n, input int bound);
    int start;
    int k;
    start = rsp_cnt;
    k = 0;
    while (rsp_cnt < start + n && k < bound) begin
      step();
      k++;
    end
    chk("rsp_count", rsp_cnt - start, n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rsp_valid"},  {31'd0, bus.rsp_valid},  32'd0);
    chk({tag, "_rsp_rdata"},  bus.rsp_rdata,           32'd0);
    chk({tag, "_rsp_err"},    {31'd0, bus.rsp_err},    32'd0);
    chk({tag, "_hbusreq"},    {31'd0, bus.hbusreq},    32'd0);
    chk({tag, "_haddr"},      bus.haddr,               32'd0);
    chk({tag, "_haddr_ctrl"}, {31'd0, bus.haddr_ctrl}, 32'd0);
    chk({tag, "_hwrite"},     {31'd0, bus.hwrite},     32'd0);
    chk({tag, "_hwdata"},     bus.hwdata,              32'd0);
    chk({tag, "_cmd_ready"},  {31'd0, bus.cmd_ready},  32'd1);
  endtask

  // Slave-side observer: address-phase tracking and response scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.haddr_ctrl && bus.hready_s2m) begin
      aph_cnt++;
      last_addr <= bus.haddr;
    end
    if (!rst && bus.rsp_valid) begin
      exp_t e;
      rsp_cnt++;
      chk("rsp_pending", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int a0;
    nchk = 0; nerr = 0; rsp_cnt = 0; aph_cnt = 0;
    last_addr = '0;
    echo = 1'b0; hdata_fix = '0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_write = 1'b0; bus.cmd_wdata = '0;
    bus.hgrant = 1'b0; bus.hready_s2m = 1'b1; bus.hresp_s2m = 1'b0;
    #1;
    chk_all_zero("reset");
    step(); step();
    rst = 1'b0;
    step();

    // Single write
    bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h100; bus.cmd_write = 1'b1;
    bus.cmd_wdata = 32'hDEAD_BEEF; bus.hgrant = 1'b1;
    expect_rsp(32'h0, 1'b0);
    step();
    bus.cmd_valid = 1'b0;
    chk("wr_c1_hbusreq", {31'd0, bus.hbusreq}, 32'd1);
    chk("wr_c1_haddr_ctrl", {31'd0, bus.haddr_ctrl}, 32'd0);
    step();
    chk("wr_c2_haddr_ctrl", {31'd0, bus.haddr_ctrl}, 32'd1);
    chk("wr_c2_haddr", bus.haddr, 32'h100);
    chk("wr_c2_hwrite", {31'd0, bus.hwrite}, 32'd1);
    step();
    chk("wr_c3_haddr_ctrl", {31'd0, bus.haddr_ctrl}, 32'd0);
    chk("wr_c3_hwdata", bus.hwdata, 32'hDEAD_BEEF);
    chk("wr_c3_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    step();
    chk("wr_c4_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("wr_c4_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    step();
    chk("wr_c5_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("wr_c5_hbusreq", {31'd0, bus.hbusreq}, 32'd0);

    // Read with two wait states
    bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h200; bus.cmd_write = 1'b0;
    hdata_fix = 32'h1234_5678;
    expect_rsp(32'h1234_5678, 1'b0);
    step();
    bus.cmd_valid = 1'b0;
    step();
    chk("rd_c2_haddr", bus.haddr, 32'h200);
    chk("rd_c2_hwrite", {31'd0, bus.hwrite}, 32'd0);
    step();
    bus.hready_s2m = 1'b0;
    step();
    chk("rd_c4_hwdata", bus.hwdata, 32'h0);
    chk("rd_c4_haddr_ctrl", {31'd0, bus.haddr_ctrl}, 32'd0);
    step();
    bus.hready_s2m = 1'b1;
    chk("rd_c5_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    step();
    chk("rd_c6_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("rd_c6_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
    step();

    // One ERROR then OKAY
    a0 = aph_cnt;
    bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h300; bus.cmd_write = 1'b0;
    bus.hresp_s2m = 1'b1; hdata_fix = 32'hCAFE_F00D;
    expect_rsp(32'hCAFE_F00D, 1'b0);
    step();
    bus.cmd_valid = 1'b0;
    step(); step(); step();
    bus.hresp_s2m = 1'b0;
    chk("retry1_c4_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    step(); step(); step();
    chk("retry1_c7_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    step();
    chk("retry1_aphases", aph_cnt - a0, 32'd2);

    // Three ERRORs exhaust the retries
    a0 = aph_cnt;
    bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h300; bus.cmd_write = 1'b0;
    bus.hresp_s2m = 1'b1; hdata_fix = 32'h7777_7777;
    expect_rsp(32'h0, 1'b1);
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("retry3_c9_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    step();
    chk("retry3_c10_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("retry3_c10_rsp_err", {31'd0, bus.rsp_err}, 32'd1);
    bus.hresp_s2m = 1'b0;
    step();
    chk("retry3_aphases", aph_cnt - a0, 32'd3);

    // Fill the FIFO with the bus withheld, then drain in order
    bus.hgrant = 1'b0; echo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full_ready_pre", {31'd0, bus.cmd_ready}, 32'd1);
      bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h400 + 32'(i * 4); bus.cmd_write = 1'b0;
      expect_rsp((32'h400 + 32'(i * 4)) ^ 32'hA5A5_0000, 1'b0);
      step();
    end
    bus.cmd_addr = 32'h500;
    chk("full_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("full_hbusreq", {31'd0, bus.hbusreq}, 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    chk("full_ready_hold", {31'd0, bus.cmd_ready}, 32'd0);
    bus.hgrant = 1'b1;
    wait_rsp(4, 40);
    step(); step();
    chk("full_sb_empty", sb.size(), 32'd0);
    echo = 1'b0;

    // Grant dropped during DATA
    bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h600; bus.cmd_write = 1'b1;
    bus.cmd_wdata = 32'h0000_0600;
    expect_rsp(32'h0, 1'b0);
    step();
    bus.cmd_addr = 32'h604; bus.cmd_wdata = 32'h0000_0604;
    expect_rsp(32'h0, 1'b0);
    step();
    bus.cmd_valid = 1'b0;
    chk("gl_c2_haddr", bus.haddr, 32'h600);
    step();
    chk("gl_c3_hwdata", bus.hwdata, 32'h0000_0600);
    bus.hgrant = 1'b0;
    step();
    chk("gl_c4_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("gl_wait_haddr_ctrl", {31'd0, bus.haddr_ctrl}, 32'd0);
      chk("gl_wait_hbusreq", {31'd0, bus.hbusreq}, 32'd1);
      step();
    end
    bus.hgrant = 1'b1;
    wait_rsp(1, 20);
    step();

    // Asynchronous reset while in DATA with commands queued
    bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h700; bus.cmd_write = 1'b0;
    step();
    bus.cmd_addr = 32'h704;
    step();
    bus.cmd_valid = 1'b0;
    step();
    bus.hready_s2m = 1'b0;
    step();
    chk("rst_in_data_hbusreq", {31'd0, bus.hbusreq}, 32'd1);
    chk("rst_in_data_ctrl", {31'd0, bus.haddr_ctrl}, 32'd0);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    step();
    rst = 1'b0; bus.hready_s2m = 1'b1;
    a0 = rsp_cnt;
    for (int i = 0; i < 10; i++) step();
    chk("rst_no_rsp", rsp_cnt - a0, 32'd0);
    chk("rst_hbusreq_idle", {31'd0, bus.hbusreq}, 32'd0);

    // Queue usable again after reset
    bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h800; bus.cmd_write = 1'b0;
    hdata_fix = 32'h0BAD_CAFE;
    expect_rsp(32'h0BAD_CAFE, 1'b0);
    step();
    bus.cmd_valid = 1'b0;
    wait_rsp(1, 20);
    for (int i = 0; i < 5; i++) step();
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
